// File: rtl/psum_engine.sv
// psum_engine: per-column psum FIFOs drain row-wise into a psum memory (write / accumulate / read); PSUM_SAT_EN selects saturating accumulate.
// Latency: write 1 clk, accumulate 2 clk (busy 1 clk), read 1 clk; pushes to a full column drop and set ovf, ops while busy or not o_valid are ignored.

module psum_fifo #(
  parameter int width = 20,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int iw = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [iw-1:0]    wr_idx, rd_idx;
  logic             wr_ph, rd_ph;
  logic             do_push, do_pop;

  // Phase bits tell full from empty when the indices meet.
  assign empty   = (wr_idx == rd_idx) && (wr_ph == rd_ph);
  assign full    = (wr_idx == rd_idx) && (wr_ph != rd_ph);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      wr_ph  <= 1'b0;
      rd_ph  <= 1'b0;
    end else begin
      if (do_push) begin
        if (wr_idx == iw'(depth - 1)) begin
          wr_idx <= '0;
          wr_ph  <= ~wr_ph;
        end else begin
          wr_idx <= wr_idx + iw'(1);
        end
      end
      if (do_pop) begin
        if (rd_idx == iw'(depth - 1)) begin
          rd_idx <= '0;
          rd_ph  <= ~rd_ph;
        end else begin
          rd_idx <= rd_idx + iw'(1);
        end
      end
    end
  end
endmodule

module psum_engine #(
  parameter  int col        = 8,
  parameter  int bw_psum    = 20,
  parameter  int fifo_depth = 8,
  parameter  int pmem_depth = 16,
  localparam int aw         = $clog2(pmem_depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic [1:0]             op,
  input  logic [aw-1:0]          add,
  output logic [bw_psum*col-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   busy,
  output logic                   ovf
);
  localparam logic [1:0] op_write = 2'b01;
  localparam logic [1:0] op_acc   = 2'b10;
  localparam logic [1:0] op_read  = 2'b11;

  logic [col-1:0][bw_psum-1:0] in_row, head_row, acc_row, acc_mem, acc_sum;
  logic [col-1:0]              col_full, col_empty;
  logic [bw_psum*col-1:0]      pmem [pmem_depth];
  logic [aw-1:0]               acc_add;
  logic                        drain, do_write, do_acc, do_read, ovf_set;

  assign in_row   = in;
  assign o_valid  = ~|col_empty;
  assign o_full   = |col_full;
  assign drain    = o_valid && !busy && ((op == op_write) || (op == op_acc));
  assign do_write = drain && (op == op_write);
  assign do_acc   = drain && (op == op_acc);
  assign do_read  = !busy && (op == op_read);
  // A drain pops every column, so a push to a full column is only lost without one.
  assign ovf_set  = |(wr & col_full & ~{col{drain}});

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_col
      logic [bw_psum:0] wide;

      psum_fifo #(.width(bw_psum), .depth(fifo_depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr[g]),
        .pop   (drain),
        .din   (in_row[g]),
        .dout  (head_row[g]),
        .full  (col_full[g]),
        .empty (col_empty[g])
      );

      assign wide = {acc_mem[g][bw_psum-1], acc_mem[g]} + {acc_row[g][bw_psum-1], acc_row[g]};
`ifdef PSUM_SAT_EN
      // Sign bits disagree only on overflow; clamp toward the sign of the true result.
      assign acc_sum[g] = (wide[bw_psum] != wide[bw_psum-1])
                        ? (wide[bw_psum] ? {1'b1, {(bw_psum-1){1'b0}}} : {1'b0, {(bw_psum-1){1'b1}}})
                        : wide[bw_psum-1:0];
`else
      assign acc_sum[g] = wide[bw_psum-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (busy)          pmem[acc_add] <= acc_sum;
    else if (do_write) pmem[add]     <= head_row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      acc_row   <= '0;
      acc_mem   <= '0;
      acc_add   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      busy      <= do_acc;
      out_valid <= do_read;
      if (do_acc) begin
        acc_row <= head_row;
        acc_mem <= pmem[add];
        acc_add <= add;
      end
      if (do_read) out <= pmem[add];
      if (ovf_set) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_engine.sv
// Scoreboard bench for psum_engine: expected read rows are queued when a read is issued and compared when out_valid appears.
module tb_psum_engine;
  localparam int col = 8;
  localparam int bw  = 20;
  localparam int W   = col * bw;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in = '0;
  logic [7:0]   wr = '0;
  logic [1:0]   op = '0;
  logic [3:0]   add = '0;
  logic [W-1:0] out;
  logic         out_valid, o_valid, o_full, busy, ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_mem [16];

  psum_engine #(.col(8), .bw_psum(20), .fifo_depth(8), .pmem_depth(16)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .op(op), .add(add),
    .out(out), .out_valid(out_valid), .o_valid(o_valid), .o_full(o_full),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic logic [W-1:0] rep(input logic [bw-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < col; i++) r[i*bw +: bw] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] seq(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < col; i++) r[i*bw +: bw] = bw'(base + i);
    return r;
  endfunction

  task automatic cyc();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected out=%h", out);
      end else begin
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL read_data got %h exp %h", out, e);
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] m, input logic [W-1:0] d);
    wr = m; in = d;
    cyc();
    wr = '0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [3:0] a);
    op = o; add = a;
    cyc();
    op = 2'b00;
  endtask

  task automatic do_read(input logic [3:0] a);
    exp_q.push_back(exp_mem[a]);
    do_op(2'b11, a);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_no_valid addr %0d pending %0d", a, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_row(input logic [3:0] a, input logic [W-1:0] d);
    push(8'hFF, d);
    do_op(2'b01, a);
    exp_mem[a] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if ({busy, ovf, o_valid, o_full, out_valid} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, ovf, o_valid, o_full, out_valid}); end
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_drain_write_read();
    push(8'hFF, seq(1));
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL dw_ovalid got %b exp 1", o_valid); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL dw_ofull got %b exp 0", o_full); end
    do_op(2'b01, 4'd3);
    exp_mem[3] = seq(1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL dw_popped got %b exp 0", o_valid); end
    do_read(4'd3);
    cyc();
    checks++; if (out !== seq(1)) begin errors++; $display("FAIL dw_out_hold got %h exp %h", out, seq(1)); end
  endtask

  task automatic test_accumulate();
    write_row(4'd6, rep(20'd7));
    write_row(4'd5, rep(20'd100));
    push(8'hFF, rep(-20'sd30));
    push(8'hFF, rep(20'd9));
    do_op(2'b10, 4'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL acc_busy got %b exp 1", busy); end
    do_op(2'b01, 4'd6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL acc_busy_end got %b exp 0", busy); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL acc_busy_ignored got %b exp 1", o_valid); end
    exp_mem[5] = rep(20'd70);
    do_read(4'd5);
    do_read(4'd6);
    do_op(2'b01, 4'd7);
    exp_mem[7] = rep(20'd9);
    do_read(4'd7);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL acc_drained got %b exp 0", o_valid); end
  endtask

  task automatic test_column_skew();
    logic [W-1:0] r;
    apply_reset();
    push(8'h01, rep(20'd11));
    push(8'h01, rep(20'd12));
    push(8'h01, rep(20'd13));
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_ovalid got %b exp 0", o_valid); end
    do_op(2'b01, 4'd8);
    push(8'hFE, seq(21));
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL skew_ovalid_all got %b exp 1", o_valid); end
    do_op(2'b01, 4'd8);
    r = seq(21);
    r[0 +: bw] = 20'd11;
    exp_mem[8] = r;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_after got %b exp 0", o_valid); end
    do_read(4'd8);
    do_read(4'd3);
  endtask

  task automatic test_full_overflow();
    logic [W-1:0] r;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      push(8'h04, rep(20'(k)));
      checks++; if (o_full !== (k == 8)) begin errors++; $display("FAIL full_push%0d got %b exp %b", k, o_full, (k == 8)); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf); end
    push(8'h04, rep(20'd99));
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    push(8'hFB, rep(20'd50));
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL full_ovalid got %b exp 1", o_valid); end
    wr = 8'h04; in = rep(20'd77); op = 2'b01; add = 4'd9;
    cyc();
    wr = '0; op = 2'b00;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_push_pop got %b exp 1", o_full); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    r = rep(20'd50);
    r[2*bw +: bw] = 20'd1;
    exp_mem[9] = r;
    do_read(4'd9);
  endtask

  task automatic test_saturation();
    logic [W-1:0] a, b, e;
    apply_reset();
    for (int i = 0; i < col; i++) begin
      a[i*bw +: bw] = (i % 2 == 0) ? 20'h7FFFF : 20'h80000;
      b[i*bw +: bw] = (i % 2 == 0) ? 20'h00001 : 20'hFFFFF;
`ifdef PSUM_SAT_EN
      e[i*bw +: bw] = (i % 2 == 0) ? 20'h7FFFF : 20'h80000;
`else
      e[i*bw +: bw] = (i % 2 == 0) ? 20'h80000 : 20'h7FFFF;
`endif
    end
    write_row(4'd10, a);
    push(8'hFF, b);
    do_op(2'b10, 4'd10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp 1", busy); end
    cyc();
    exp_mem[10] = e;
    do_read(4'd10);
  endtask

  task automatic test_reset_during_acc();
    apply_reset();
    write_row(4'd11, rep(20'd5));
    for (int k = 0; k < 9; k++) push(8'h02, rep(20'd3));
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rda_ovf_pre got %b exp 1", ovf); end
    push(8'hFD, rep(20'd3));
    do_op(2'b10, 4'd11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rda_busy got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rda_busy_clr got %b exp 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rda_ovf_clr got %b exp 0", ovf); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rda_ovalid got %b exp 0", o_valid); end
    cyc();
    reset = 1'b1;
    cyc();
    do_read(4'd11);
  endtask

  task automatic test_back_to_back();
    push(8'hFF, rep(20'd2));
    do_op(2'b10, 4'd3);
    wr = 8'hFF; in = rep(20'd4); op = 2'b11; add = 4'd3;
    cyc();
    wr = '0; op = 2'b00;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_push_busy got %b exp 1", o_valid); end
    exp_mem[3] = seq(3);
    do_read(4'd3);
    do_read(4'd10);
    do_read(4'd11);
    do_op(2'b01, 4'd12);
    exp_mem[12] = rep(20'd4);
    do_read(4'd12);
  endtask

  initial begin
    test_reset();
    test_drain_write_read();
    test_accumulate();
    test_column_skew();
    test_full_overflow();
    test_saturation();
    test_reset_during_acc();
    test_back_to_back();
    cyc(); cyc();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
